// File: rtl/dirty_line_walker.sv
`default_nettype none
// ============================================================================
// Module      : dirty_line_walker
// Description : Walks a 1-bit-per-line cache state memory on a flush request.
//               Each set bit produces a valid/ready writeback request and is
//               then cleared through the memory write port.
// Options     : DIRTY_WALKER_WB_COUNT_EN adds the WB_COUNT output, the number
//               of writebacks accepted in the current or most recent walk.
// Revision    : 1.0 - initial release
// ============================================================================
module dirty_line_walker #(
  parameter int DEPTH         = 512,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     FLUSH_REQ,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [ADDRESS_WIDTH-1:0] ST_RADDR,
  input  logic                     ST_STATE,
  output logic                     ST_WREN,
  output logic [ADDRESS_WIDTH-1:0] ST_WADDR,
  output logic                     ST_WDATA,
  output logic                     WB_VALID,
  output logic [ADDRESS_WIDTH-1:0] WB_INDEX,
  input  logic                     WB_READY
`ifdef DIRTY_WALKER_WB_COUNT_EN
  ,
  output logic [ADDRESS_WIDTH:0]   WB_COUNT
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_ISSUE = 3'd2,
    S_CLEAR = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  // Terminal compare against DEPTH-1 keeps non-power-of-two depths in range.
  localparam logic [ADDRESS_WIDTH-1:0] c_LAST_IDX = ADDRESS_WIDTH'(DEPTH - 1);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;
  logic                     w_last;

  assign w_last = (idx_q == c_LAST_IDX);

  // State and index registers; reset abandons any walk in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and index update; one index examined per SCAN cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (FLUSH_REQ) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        if (ST_STATE) begin
          state_d = S_ISSUE;
        end else if (w_last) begin
          state_d = S_FIN;
        end else begin
          idx_d = idx_q + ADDRESS_WIDTH'(1);
        end
      end
      S_ISSUE: begin
        // Request is held, index frozen, until the consumer accepts it.
        if (WB_READY) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (w_last) begin
          state_d = S_FIN;
        end else begin
          state_d = S_SCAN;
          idx_d   = idx_q + ADDRESS_WIDTH'(1);
        end
      end
      S_FIN: begin
        // FLUSH_REQ is deliberately not looked at here.
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs decode registered state only, so no input reaches them combinationally.
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = (state_q == S_FIN);
  assign WB_VALID = (state_q == S_ISSUE);
  assign ST_WREN  = (state_q == S_CLEAR);
  assign ST_WDATA = 1'b0;
  assign ST_RADDR = idx_q;
  assign ST_WADDR = idx_q;
  assign WB_INDEX = idx_q;

`ifdef DIRTY_WALKER_WB_COUNT_EN
  logic [ADDRESS_WIDTH:0] count_q;

  // Accepted-writeback counter; cleared when a walk starts, held after it ends.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else if (state_q == S_IDLE && FLUSH_REQ) begin
      count_q <= '0;
    end else if (state_q == S_ISSUE && WB_READY) begin
      count_q <= count_q + (ADDRESS_WIDTH + 1)'(1);
    end
  end

  assign WB_COUNT = count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dirty_line_walker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dirty_line_walker
// Description : Self-checking bench for dirty_line_walker (DEPTH = 8) with a
//               behavioural state memory and a per-walk reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dirty_line_walker;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          FLUSH_REQ;
  logic          ST_STATE;
  logic          WB_READY;
  logic          BUSY, DONE, ST_WREN, ST_WDATA, WB_VALID;
  logic [AW-1:0] ST_RADDR, ST_WADDR, WB_INDEX;
`ifdef DIRTY_WALKER_WB_COUNT_EN
  logic [AW:0]   WB_COUNT;
`endif

  // Behavioural state memory: combinational read, clocked write or bulk load.
  logic [DEPTH-1:0] mem_q;
  logic             load_en;
  logic [DEPTH-1:0] load_val;

  int checks = 0;
  int errors = 0;

  dirty_line_walker #(.DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .FLUSH_REQ(FLUSH_REQ),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ST_RADDR (ST_RADDR),
    .ST_STATE (ST_STATE),
    .ST_WREN  (ST_WREN),
    .ST_WADDR (ST_WADDR),
    .ST_WDATA (ST_WDATA),
    .WB_VALID (WB_VALID),
    .WB_INDEX (WB_INDEX),
    .WB_READY (WB_READY)
`ifdef DIRTY_WALKER_WB_COUNT_EN
    ,
    .WB_COUNT (WB_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  assign ST_STATE = mem_q[ST_RADDR];

  always @(posedge CLK) begin
    if (load_en) mem_q <= load_val;
    else if (ST_WREN) mem_q[ST_WADDR] <= ST_WDATA;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_mem(input logic [DEPTH-1:0] pat);
    @(negedge CLK);
    load_val = pat;
    load_en  = 1'b1;
    @(negedge CLK);
    load_en  = 1'b0;
  endtask

  // ready_mode: 0 = always ready, 1 = random, 2 = hold off 4 cycles per request.
  task automatic run_walk(input string name, input logic [DEPTH-1:0] pat,
                          input int ready_mode, input int exp_done_given, input bit repulse);
    int   exp_wb[$];
    int   got_wb[$];
    int   got_clr[$];
    int   stalls, cyc, done_cnt, done_cyc, viol, wait_cnt, budget, exp_done;
    bit   pend_v, pend_clr, ready, seq_ok, clr_ok;
    logic [AW-1:0] pend_idx;
    stalls = 0; done_cnt = 0; done_cyc = -1; viol = 0; wait_cnt = 0;
    pend_v = 1'b0; pend_clr = 1'b0; pend_idx = '0;
    budget = 4 * DEPTH + 400;

    for (int i = 0; i < DEPTH; i++) if (pat[i]) exp_wb.push_back(i);

    load_mem(pat);
    FLUSH_REQ = 1'b1;
    @(posedge CLK);
    #1;
    FLUSH_REQ = 1'b0;
    cyc = 1;
    chk($sformatf("%s start index", name), 32'(ST_RADDR), 0);
    chk($sformatf("%s busy at start", name), 32'(BUSY), 1);

    while (cyc <= budget) begin
      if (DONE === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (BUSY !== ((done_cyc < 0 || cyc == done_cyc) ? 1'b1 : 1'b0)) viol++;
      if (ST_RADDR !== ST_WADDR || ST_RADDR !== WB_INDEX) viol++;
      if (pend_v && !(WB_VALID === 1'b1 && WB_INDEX === pend_idx)) viol++;
      if (ST_WREN === 1'b1) begin
        got_clr.push_back(int'(ST_WADDR));
        if (ST_WDATA !== 1'b0) viol++;
        if (!pend_clr) viol++;
      end else if (pend_clr) begin
        viol++;
      end
      if (ST_WREN === 1'b1 && got_wb.size() > 0 && int'(ST_WADDR) != got_wb[$]) viol++;

      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = ($urandom_range(0, 3) != 0);
        default: ready = (wait_cnt >= 4);
      endcase
      WB_READY = ready;

      pend_clr = 1'b0;
      if (WB_VALID === 1'b1) begin
        if (ready) begin
          got_wb.push_back(int'(WB_INDEX));
          pend_clr = 1'b1;
          pend_v   = 1'b0;
          wait_cnt = 0;
        end else begin
          stalls++;
          pend_v   = 1'b1;
          pend_idx = WB_INDEX;
          wait_cnt++;
        end
      end else begin
        pend_v = 1'b0;
      end

      if (repulse && (cyc == 3 || DONE === 1'b1)) FLUSH_REQ = 1'b1;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(posedge CLK);
      #1;
      FLUSH_REQ = 1'b0;
      cyc++;
    end
    WB_READY = 1'b1;

    exp_done = (exp_done_given >= 0) ? exp_done_given : DEPTH + 2 * exp_wb.size() + stalls + 1;
    seq_ok = (got_wb.size() == exp_wb.size());
    clr_ok = (got_clr.size() == exp_wb.size());
    for (int i = 0; i < exp_wb.size(); i++) begin
      if (i < got_wb.size()  && got_wb[i]  != exp_wb[i]) seq_ok = 1'b0;
      if (i < got_clr.size() && got_clr[i] != exp_wb[i]) clr_ok = 1'b0;
    end
    chk($sformatf("%s done pulses", name), 32'(done_cnt), 1);
    chk($sformatf("%s done cycle", name), 32'(done_cyc), 32'(exp_done));
    chk($sformatf("%s writeback count", name), 32'(got_wb.size()), 32'(exp_wb.size()));
    chk($sformatf("%s writeback order", name), 32'(seq_ok), 1);
    chk($sformatf("%s clear order", name), 32'(clr_ok), 1);
    chk($sformatf("%s protocol violations", name), 32'(viol), 0);
    chk($sformatf("%s memory cleared", name), 32'(mem_q), 0);
`ifdef DIRTY_WALKER_WB_COUNT_EN
    chk($sformatf("%s WB_COUNT", name), 32'(WB_COUNT), 32'(exp_wb.size()));
`endif
  endtask

  typedef struct {
    logic [DEPTH-1:0] pat;
    int               ready_mode;
    int               exp_done;
    bit               repulse;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{pat: 8'h00, ready_mode: 0, exp_done: 9,  repulse: 1'b0};
    vecs[1] = '{pat: 8'h24, ready_mode: 0, exp_done: 13, repulse: 1'b0};
    vecs[2] = '{pat: 8'h80, ready_mode: 2, exp_done: 15, repulse: 1'b0};
    vecs[3] = '{pat: 8'hFF, ready_mode: 0, exp_done: 25, repulse: 1'b0};
    vecs[4] = '{pat: 8'h01, ready_mode: 0, exp_done: 11, repulse: 1'b0};
    vecs[5] = '{pat: 8'h24, ready_mode: 0, exp_done: 13, repulse: 1'b1};

    RST = 1'b1; FLUSH_REQ = 1'b0; WB_READY = 1'b0; load_en = 1'b0; load_val = '0;
    #1;
    chk("reset BUSY", 32'(BUSY), 0);
    chk("reset DONE", 32'(DONE), 0);
    chk("reset WB_VALID", 32'(WB_VALID), 0);
    chk("reset ST_WREN", 32'(ST_WREN), 0);
    chk("reset indices", 32'({ST_RADDR, ST_WADDR, WB_INDEX, ST_WDATA}), 0);
`ifdef DIRTY_WALKER_WB_COUNT_EN
    chk("reset WB_COUNT", 32'(WB_COUNT), 0);
`endif
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    for (int v = 0; v < 6; v++)
      run_walk($sformatf("vec%0d", v), vecs[v].pat, vecs[v].ready_mode,
               vecs[v].exp_done, vecs[v].repulse);

    // Reset while a request at index 3 is outstanding.
    WB_READY = 1'b0;
    load_mem(8'h48);
    FLUSH_REQ = 1'b1;
    @(posedge CLK);
    #1;
    FLUSH_REQ = 1'b0;
    n = 0;
    while (WB_VALID !== 1'b1 && n < 40) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("rst-mid issue reached", 32'(WB_VALID), 1);
    chk("rst-mid issue index", 32'(WB_INDEX), 3);
    #2;
    RST = 1'b1;
    #1;
    chk("rst-mid WB_VALID drop", 32'(WB_VALID), 0);
    chk("rst-mid BUSY drop", 32'(BUSY), 0);
    chk("rst-mid ST_WREN", 32'(ST_WREN), 0);
    n = 0;
    repeat (3) begin
      @(posedge CLK);
      #1;
      if (DONE !== 1'b0 || ST_WREN !== 1'b0) n++;
    end
    chk("rst-mid no done or write", 32'(n), 0);
    chk("rst-mid bit 3 kept", 32'(mem_q[3]), 1);
    @(negedge CLK);
    RST = 1'b0;
    run_walk("after reset", 8'h48, 0, 13, 1'b0);

    for (int r = 0; r < 12; r++)
      run_walk($sformatf("rand%0d", r), DEPTH'($urandom), 1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dirty_line_walker.md
Name: dirty_line_walker

Overview:
- Sequential reader and clearer for a 1-bit-per-line cache state memory, such as a dirty-bit or valid-bit array.
- On a flush request it scans every index in order.
- For each index whose state bit is set, it issues a writeback request over a valid/ready handshake, then clears that bit through the memory's write port.
- Sits between the cache controller's flush logic and the state memory; drives that memory's read address and write port during a walk.

Parameters:
- depth, 512, number of lines (entries) in the state memory being walked.
- address_width, $clog2(depth), width of index/address buses.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- FLUSH_REQ  input  1  start a walk; sampled only in IDLE.
- BUSY  output  1  high while a walk is in progress (any state except IDLE).
- DONE  output  1  one-cycle pulse when a walk completes.
- ST_RADDR  output  address_width  read address to the state memory.
- ST_STATE  input  1  state bit at ST_RADDR; combinational, valid in the same cycle.
- ST_WREN  output  1  write enable to the state memory.
- ST_WADDR  output  address_width  write address.
- ST_WDATA  output  1  write data; always 0.
- WB_VALID  output  1  writeback request valid.
- WB_INDEX  output  address_width  line index of the writeback request.
- WB_READY  input  1  writeback consumer accepts the request.

Behaviour:
- Reset, asynchronous:
  - state = IDLE, index counter idx = 0.
  - BUSY, DONE, ST_WREN, WB_VALID = 0.
  - ST_RADDR, ST_WADDR, WB_INDEX = 0; ST_WDATA = 0.
  - Reset mid-walk abandons the walk immediately: no further clear write, no DONE.
- ST_RADDR = ST_WADDR = WB_INDEX = idx at all times.
- FSM states: IDLE, SCAN, ISSUE, CLEAR, FIN.
- IDLE:
  - BUSY = 0.
  - FLUSH_REQ = 1 at an edge -> SCAN, idx <= 0.
- SCAN:
  - One index examined per cycle.
  - ST_STATE = 1 -> ISSUE (idx held).
  - Else if idx == depth-1 -> FIN.
  - Else idx <= idx+1, stay in SCAN.
- ISSUE:
  - WB_VALID = 1; WB_INDEX stable until accepted.
  - WB_READY = 1 -> CLEAR.
  - WB_READY = 0 -> hold in ISSUE indefinitely; no timeout.
  - WB_VALID must never drop before acceptance.
- CLEAR:
  - ST_WREN = 1 for exactly one cycle, ST_WDATA = 0, ST_WADDR = idx.
  - Then: idx == depth-1 -> FIN; else idx <= idx+1 -> SCAN.
- FIN:
  - DONE = 1 for one cycle, then -> IDLE.
  - idx <= 0 on that transition.
- FLUSH_REQ while BUSY is ignored. It is not queued.
- FLUSH_REQ asserted in the FIN cycle is ignored. It must be re-asserted once IDLE is reached.
- BUSY = 1 in SCAN, ISSUE, CLEAR and FIN.
- Timing:
  - The SCAN cycle for index 0 follows the edge that sampled FLUSH_REQ.
  - A walk with k set bits and WB_READY tied high takes depth + 2k cycles of SCAN/ISSUE/CLEAR, then 1 cycle of FIN.
- Counter arithmetic:
  - idx is address_width bits.
  - The terminal test is idx == depth-1, so non-power-of-two depth never wraps past depth-1.
  - idx never increments from depth-1.
- Last index: a set bit at index depth-1 still gets ISSUE and CLEAR before FIN.
- Outputs are driven from registered state and idx. WB_VALID and ST_WREN have no combinational path from inputs.

Optional Feature:
- Macro: DIRTY_WALKER_WB_COUNT_EN.
- Defined:
  - Adds output WB_COUNT, width address_width+1.
  - Counts accepted writebacks (ISSUE && WB_READY) in the current or most recent walk.
  - Cleared to 0 on RST and on the IDLE->SCAN transition.
  - Holds its value after DONE until the next walk starts.
  - Maximum value is depth (every line set).
- Undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- depth=8, all bits 0, FLUSH_REQ pulsed at edge 0, WB_READY=1 -> no WB_VALID, no ST_WREN; DONE high exactly in cycle 9 only; BUSY high in cycles 1..9.
- depth=8, bits at 2 and 5 set, WB_READY=1 -> WB_VALID with WB_INDEX=2 then 5, each followed by one ST_WREN to the same address with data 0; DONE in cycle 13; memory all zero afterwards; WB_COUNT=2 when the macro is defined.
- depth=8, bit 7 only set, WB_READY held 0 for 4 cycles in ISSUE:
  - WB_VALID stays 1 with WB_INDEX stable at 7 for all 4 cycles.
  - On the READY edge, the CLEAR of address 7 occurs.
  - DONE follows immediately; no idx wrap to 0.
- All 8 bits set, WB_READY=1 -> 8 writebacks, indices 0..7 in order; DONE in cycle 25; WB_COUNT=8 when the macro is defined.
- RST asserted asynchronously while in ISSUE at index 3 -> WB_VALID, BUSY and ST_WREN drop immediately; bit 3 not cleared; no DONE; the next FLUSH_REQ restarts at index 0.
- FLUSH_REQ re-pulsed during SCAN and during FIN -> ignored; exactly one DONE; BUSY low after FIN.
